sattn_cmd_sched: RTL and testbench

Parametrised command front-end for the sparse-attention accelerator. It replaces the single-command latch-and-run controller with an MMIO-fed command FIFO. Commands are dispatched serially to NUM_ENG engine channels (spdot, softmax, spmm, gather, …) over a start/done handshake. Per-engine checksums are captured, hangs are caught by a timeout, and completion is signalled by a maskable interrupt.

---
 rtl/sattn_cmd_sched.sv | 168 ++++++++++++++++
 tb/tb_sattn_cmd_sched.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sattn_cmd_sched.sv
// Command front-end for the sparse-attention accelerator: MMIO-fed command FIFO,
// serial dispatch to engine channels, checksum capture, timeout and maskable irq.
module sattn_cmd_sched #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 64,
    parameter int NUM_ENG    = 4,
    parameter int Q_DEPTH    = 4,
    parameter int TO_W       = 20
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    mmio_wen,
    input  logic                    mmio_ren,
    input  logic [ADDR_WIDTH-1:0]   mmio_addr,
    input  logic [DATA_WIDTH-1:0]   mmio_wdata,
    output logic [DATA_WIDTH-1:0]   mmio_rdata,
    output logic [NUM_ENG-1:0]      eng_start,
    output logic [7:0]              eng_opcode,
    input  logic [NUM_ENG-1:0]      eng_done,
    input  logic [NUM_ENG*64-1:0]   eng_sum,
    output logic                    busy,
    output logic                    irq
);
    localparam int PW = $clog2(Q_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t              state_q, state_d;
    logic [15:0]         fifo_q [Q_DEPTH];
    logic [PW-1:0]       wptr_q, rptr_q;
    logic [CW-1:0]       cnt_q;
    logic [EW-1:0]       eng_q, eng_d;
    logic [7:0]          op_q, op_d;
    logic [TO_W-1:0]     tmo_cnt_q, tmo_cnt_d;
    logic [TO_W-1:0]     to_lim_q;
    logic [63:0]         sum_q [NUM_ENG];
    logic                ovf_q, tmo_q, bad_q;
    logic                irq_en_q, irq_pend_q;
    logic [7:0]          cmpl_q;

    logic wr_push, wr_irqen, wr_clr, wr_tolim;
    logic full, empty, push_ok, pop;
    logic [15:0] head;
    logic head_bad, done_hit, tmo_hit;
    logic ovf_set, tmo_set, bad_set, irq_set;

    assign wr_push  = mmio_wen && (mmio_addr == ADDR_WIDTH'('h00));
    assign wr_irqen = mmio_wen && (mmio_addr == ADDR_WIDTH'('h10));
    assign wr_clr   = mmio_wen && (mmio_addr == ADDR_WIDTH'('h18));
    assign wr_tolim = mmio_wen && (mmio_addr == ADDR_WIDTH'('h20));

    assign full     = (cnt_q == CW'(Q_DEPTH));
    assign empty    = (cnt_q == '0);
    assign push_ok  = wr_push && !full;
    assign pop      = (state_q == IDLE) && !empty;
    assign head     = fifo_q[rptr_q];
    assign head_bad = ({24'b0, head[15:8]} >= 32'(NUM_ENG));

    assign done_hit = eng_done[eng_q];
    assign tmo_hit  = (to_lim_q != '0) && (tmo_cnt_q == to_lim_q - TO_W'(1));

    assign ovf_set  = wr_push && full;
    assign bad_set  = pop && head_bad;
    assign tmo_set  = (state_q == WAIT) && !done_hit && tmo_hit;
    assign irq_set  = (state_q == DONE) && irq_en_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (pop && !head_bad)
                         state_d = (head[7:0] == 8'h00) ? DONE : ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (done_hit || tmo_hit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        eng_start = '0;
        if (state_q == ISSUE) eng_start[eng_q] = 1'b1;
        eng_opcode = op_q;
        busy       = (state_q != IDLE) || !empty;
        irq        = irq_pend_q;
    end

    always_comb begin
        eng_d     = eng_q;
        op_d      = op_q;
        tmo_cnt_d = tmo_cnt_q;
        if (pop && !head_bad && head[7:0] != 8'h00) begin
            eng_d = head[EW-1+8:8];
            op_d  = head[7:0];
        end
        if (state_q == ISSUE)
            tmo_cnt_d = '0;
        else if (state_q == WAIT && !done_hit && !tmo_hit)
            tmo_cnt_d = tmo_cnt_q + TO_W'(1);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < Q_DEPTH; i++) fifo_q[i] <= '0;
            for (int i = 0; i < NUM_ENG; i++) sum_q[i] <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
            eng_q      <= '0;
            op_q       <= '0;
            tmo_cnt_q  <= '0;
            to_lim_q   <= '0;
            ovf_q      <= 1'b0;
            tmo_q      <= 1'b0;
            bad_q      <= 1'b0;
            irq_en_q   <= 1'b0;
            irq_pend_q <= 1'b0;
            cmpl_q     <= '0;
        end else begin
            if (push_ok) begin
                fifo_q[wptr_q] <= mmio_wdata[15:0];
                wptr_q         <= wptr_q + PW'(1);
            end
            if (pop) rptr_q <= rptr_q + PW'(1);
            cnt_q     <= cnt_q + CW'(push_ok) - CW'(pop);
            eng_q     <= eng_d;
            op_q      <= op_d;
            tmo_cnt_q <= tmo_cnt_d;
            if (state_q == WAIT && done_hit)
                sum_q[eng_q] <= eng_sum[32'(eng_q)*64 +: 64];
            if (state_q == DONE) cmpl_q <= cmpl_q + 8'd1;
            if (wr_irqen) irq_en_q <= mmio_wdata[0];
            if (wr_tolim) to_lim_q <= mmio_wdata[TO_W-1:0];
            // a flag raised in the same cycle as its clear stays raised
            ovf_q      <= (ovf_q      & ~(wr_clr & mmio_wdata[4])) | ovf_set;
            tmo_q      <= (tmo_q      & ~(wr_clr & mmio_wdata[5])) | tmo_set;
            bad_q      <= (bad_q      & ~(wr_clr & mmio_wdata[6])) | bad_set;
            irq_pend_q <= (irq_pend_q & ~(wr_clr & mmio_wdata[7])) | irq_set;
        end
    end

    logic [23:0]           status;
    logic [ADDR_WIDTH-1:0] sum_off;
    logic [EW-1:0]         sum_idx;
    logic                  sum_hit;

    assign status  = {cmpl_q, 8'(cnt_q), 1'b0, bad_q, tmo_q, ovf_q,
                      empty, full, busy, state_q == IDLE};
    assign sum_off = mmio_addr - ADDR_WIDTH'('h40);
    assign sum_idx = sum_off[3 +: EW];
    assign sum_hit = (mmio_addr >= ADDR_WIDTH'('h40))
                  && (mmio_addr < ADDR_WIDTH'(64 + 8*NUM_ENG))
                  && (mmio_addr[2:0] == 3'b000);

    always_comb begin
        mmio_rdata = '0;
        if (mmio_addr == ADDR_WIDTH'('h08))      mmio_rdata = DATA_WIDTH'(status);
        else if (mmio_addr == ADDR_WIDTH'('h10)) mmio_rdata = DATA_WIDTH'(irq_en_q);
        else if (mmio_addr == ADDR_WIDTH'('h20)) mmio_rdata = DATA_WIDTH'(to_lim_q);
        else if (sum_hit)                        mmio_rdata = DATA_WIDTH'(sum_q[sum_idx]);
    end
endmodule

// File: tb/tb_sattn_cmd_sched.sv
// Bench for sattn_cmd_sched: directed scenarios plus random traffic,
// all checked each cycle against a queue-based command model.
module tb_sattn_cmd_sched;
    localparam int AW = 16;
    localparam int DW = 64;
    localparam int NE = 4;
    localparam int QD = 4;
    localparam int TW = 20;
    localparam int P_IDLE = 0, P_ISSUE = 1, P_WAIT = 2, P_DONE = 3;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic           wen = 1'b0;
    logic           ren = 1'b1;
    logic [AW-1:0]  addr = 16'h08;
    logic [DW-1:0]  wdata = '0;
    logic [DW-1:0]  rdata;
    logic [NE-1:0]  eng_start;
    logic [7:0]     eng_opcode;
    logic [NE-1:0]  eng_done = '0;
    logic [NE*64-1:0] eng_sum = '0;
    logic           busy, irq;

    sattn_cmd_sched #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_ENG(NE),
                      .Q_DEPTH(QD), .TO_W(TW)) dut (
        .clk(clk), .rstn(rstn), .mmio_wen(wen), .mmio_ren(ren),
        .mmio_addr(addr), .mmio_wdata(wdata), .mmio_rdata(rdata),
        .eng_start(eng_start), .eng_opcode(eng_opcode),
        .eng_done(eng_done), .eng_sum(eng_sum), .busy(busy), .irq(irq));

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    endtask

    // behavioural model: pending commands, the one in flight and its phase
    logic [15:0]   mq[$];
    int            ph, m_eng, m_tcnt;
    logic [7:0]    m_op, m_cmpl;
    logic [63:0]   m_sum [NE];
    logic          m_ovf, m_tmo, m_bad, m_irqen, m_irqp;
    logic [TW-1:0] m_tol;

    int         s_cnt = 0;
    logic [7:0] started_ops[$];

    task automatic model_reset();
        mq.delete();
        ph = P_IDLE; m_eng = 0; m_tcnt = 0; m_op = '0; m_cmpl = '0;
        for (int i = 0; i < NE; i++) m_sum[i] = '0;
        m_ovf = 0; m_tmo = 0; m_bad = 0; m_irqen = 0; m_irqp = 0; m_tol = '0;
    endtask

    function automatic logic [63:0] mread(input logic [15:0] a);
        logic [63:0] r = '0;
        int sz = mq.size();
        if (a == 16'h08)
            r = {40'b0, m_cmpl, 8'(sz), 1'b0, m_bad, m_tmo, m_ovf,
                 sz == 0, sz == QD, (ph != P_IDLE) || (sz != 0), ph == P_IDLE};
        else if (a == 16'h10) r = {63'b0, m_irqen};
        else if (a == 16'h20) r = 64'(m_tol);
        else if (a >= 16'h40 && a < 16'(64 + 8*NE) && a[2:0] == 3'b000)
            r = m_sum[int'((a - 16'h40) >> 3)];
        return r;
    endfunction

    task automatic model_step();
        logic [15:0] h;
        int e, nph;
        bit push_req, full, clr, ovf_s, tmo_s, bad_s, irq_s;
        nph = ph;
        ovf_s = 0; tmo_s = 0; bad_s = 0; irq_s = 0;
        full = (mq.size() == QD);
        push_req = wen && addr == 16'h00;
        if (push_req && full) ovf_s = 1;
        case (ph)
            P_IDLE: if (mq.size() > 0) begin
                h = mq.pop_front();
                e = int'(h[15:8]);
                if (e >= NE) bad_s = 1;
                else if (h[7:0] == 8'h00) nph = P_DONE;
                else begin m_eng = e; m_op = h[7:0]; nph = P_ISSUE; end
            end
            P_ISSUE: begin m_tcnt = 0; nph = P_WAIT; end
            P_WAIT: begin
                if (eng_done[m_eng]) begin
                    m_sum[m_eng] = eng_sum[m_eng*64 +: 64];
                    nph = P_DONE;
                end else if (m_tol != 0 && m_tcnt == int'(m_tol) - 1) begin
                    tmo_s = 1;
                    nph = P_DONE;
                end else m_tcnt = (m_tcnt + 1) % (1 << TW);
            end
            default: begin
                m_cmpl = m_cmpl + 8'd1;
                if (m_irqen) irq_s = 1;
                nph = P_IDLE;
            end
        endcase
        if (push_req && !full) mq.push_back(wdata[15:0]);
        clr = wen && addr == 16'h18;
        m_ovf = (m_ovf && !(clr && wdata[4])) || ovf_s;
        m_tmo = (m_tmo && !(clr && wdata[5])) || tmo_s;
        m_bad = (m_bad && !(clr && wdata[6])) || bad_s;
        m_irqp = (m_irqp && !(clr && wdata[7])) || irq_s;
        if (wen && addr == 16'h10) m_irqen = wdata[0];
        if (wen && addr == 16'h20) m_tol = wdata[TW-1:0];
        ph = nph;
    endtask

    initial forever begin
        logic [NE-1:0] es;
        @(negedge clk);
        if (!rstn) model_reset();
        if (eng_start != '0) begin
            s_cnt++;
            started_ops.push_back(eng_opcode);
        end
        es = '0;
        if (ph == P_ISSUE) es[m_eng] = 1'b1;
        chk("eng_start", 64'(eng_start), 64'(es));
        chk("busy", 64'(busy), 64'((ph != P_IDLE) || (mq.size() != 0)));
        chk("irq", 64'(irq), 64'(m_irqp));
        chk("rdata", rdata, mread(addr));
        if (ph == P_ISSUE || ph == P_WAIT) chk("opcode", 64'(eng_opcode), 64'(m_op));
        if (rstn) model_step();
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [63:0] d);
        wen = 1'b1; addr = a; wdata = d;
        tick();
        wen = 1'b0; addr = 16'h08;
    endtask

    task automatic rd(input logic [15:0] a, output logic [63:0] d);
        addr = a;
        @(negedge clk);
        d = rdata;
        tick();
    endtask

    task automatic drain(input string nm);
        bit ok = 0;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            ok = !busy;
        end
        tick();
        chk(nm, 64'(ok), 64'd1);
    endtask

    logic [63:0] d;
    logic [7:0]  c0;
    int          s0;
    logic [7:0]  ov_exp [5] = '{8'h21, 8'h31, 8'h32, 8'h33, 8'h34};
    logic [15:0] raddrs [13] = '{16'h00, 16'h08, 16'h10, 16'h18, 16'h20, 16'h40,
                                 16'h48, 16'h50, 16'h58, 16'h60, 16'h44, 16'h30, 16'hFFF8};
    logic [15:0] junk [4] = '{16'h28, 16'h38, 16'h40, 16'h60};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;

        // reset state
        rd(16'h08, d);
        chk("reset_status", d, 64'h9);
        chk("reset_irq", 64'(irq), 64'd0);

        // single command, done 5 cycles after start
        s0 = s_cnt;
        wr(16'h00, 64'h0114);
        tick();
        tick();
        repeat (4) tick();
        eng_done = 4'b0010;
        eng_sum[64 +: 64] = 64'hDEADBEEF;
        tick();
        eng_done = '0;
        @(negedge clk);
        chk("busy_in_done", 64'(busy), 64'd1);
        tick();
        @(negedge clk);
        chk("busy_after_done", 64'(busy), 64'd0);
        tick();
        chk("t1_pulses", 64'(s_cnt - s0), 64'd1);
        rd(16'h48, d);
        chk("t1_sum1", d, 64'hDEADBEEF);
        rd(16'h08, d);
        chk("t1_cmpl", 64'(d[23:16]), 64'd1);

        // bad engine then NOP
        s0 = s_cnt;
        wr(16'h00, 64'h0712);
        wr(16'h00, 64'h0000);
        repeat (4) tick();
        rd(16'h08, d);
        chk("bad_flag", 64'(d[6]), 64'd1);
        chk("bad_cmpl", 64'(d[23:16]), 64'd2);
        chk("bad_pulses", 64'(s_cnt - s0), 64'd0);

        // overflow while blocked in WAIT
        wr(16'h18, 64'h70);
        started_ops.delete();
        wr(16'h00, 64'h0021);
        tick();
        tick();
        wr(16'h00, 64'h0131);
        wr(16'h00, 64'h0232);
        wr(16'h00, 64'h0333);
        wr(16'h00, 64'h0034);
        wr(16'h00, 64'h0135);
        rd(16'h08, d);
        chk("ovf_status", 64'(d[15:0]), 64'h0416);
        c0 = d[23:16];
        eng_done = 4'hF;
        drain("ovf_drain");
        eng_done = '0;
        rd(16'h08, d);
        chk("ovf_cmpl", 64'(d[23:16] - c0), 64'd5);
        chk("ovf_nstart", 64'(started_ops.size()), 64'd5);
        for (int i = 0; i < 5; i++) chk("ovf_order", 64'(started_ops[i]), 64'(ov_exp[i]));

        // timeout on silent engine 2
        wr(16'h20, 64'd10);
        wr(16'h18, 64'h70);
        started_ops.delete();
        wr(16'h00, 64'h0255);
        wr(16'h00, 64'h0066);
        tick();
        repeat (9) tick();
        rd(16'h08, d);
        chk("tmo_early", 64'(d[5]), 64'd0);
        rd(16'h08, d);
        chk("tmo_set", 64'(d[5]), 64'd1);
        eng_done = 4'b0001;
        drain("tmo_drain");
        eng_done = '0;
        rd(16'h50, d);
        chk("tmo_sum2", d, 64'h0);
        chk("tmo_nstart", 64'(started_ops.size()), 64'd2);
        chk("tmo_next", 64'(started_ops[1]), 64'h66);

        // irq set beats same-cycle clear
        wr(16'h10, 64'h1);
        wr(16'h00, 64'h0000);
        tick();
        tick();
        @(negedge clk);
        chk("irq_first", 64'(irq), 64'd1);
        tick();
        wr(16'h00, 64'h0000);
        tick();
        wr(16'h18, 64'h80);
        @(negedge clk);
        chk("irq_set_wins", 64'(irq), 64'd1);
        tick();
        wr(16'h18, 64'h80);
        @(negedge clk);
        chk("irq_cleared", 64'(irq), 64'd0);
        tick();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            int r;
            for (int e = 0; e < NE; e++) begin
                eng_done[e] = ($urandom_range(0, 3) == 0);
                eng_sum[e*64 +: 64] = {$urandom, $urandom};
            end
            r = $urandom_range(0, 99);
            wdata = {$urandom, $urandom};
            wen = 1'b1;
            if (r < 20) begin
                addr = 16'h00;
                wdata[15:8] = 8'($urandom_range(0, 5));
                wdata[7:0] = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            end else if (r < 23) addr = 16'h18;
            else if (r < 25) addr = 16'h10;
            else if (r < 27) begin
                addr = 16'h20;
                wdata[TW-1:0] = TW'($urandom_range(0, 12));
            end else if (r < 29) addr = junk[$urandom_range(0, 3)];
            else begin
                wen = 1'b0;
                addr = raddrs[$urandom_range(0, 12)];
            end
            tick();
        end
        wen = 1'b0;
        addr = 16'h08;
        wr(16'h20, 64'd0);
        eng_done = 4'hF;
        drain("rand_drain");
        eng_done = '0;

        // reset in WAIT with two queued and irq pending
        wr(16'h10, 64'h1);
        wr(16'h00, 64'h0000);
        repeat (3) tick();
        wr(16'h00, 64'h0141);
        tick();
        tick();
        wr(16'h00, 64'h0242);
        wr(16'h00, 64'h0343);
        rd(16'h08, d);
        chk("pre_reset_cnt", 64'(d[15:8]), 64'd2);
        rstn = 1'b0;
        rd(16'h08, d);
        chk("rst_status", d, 64'h9);
        chk("rst_irq", 64'(irq), 64'd0);
        chk("rst_start", 64'(eng_start), 64'd0);
        tick();
        rstn = 1'b1;
        s0 = s_cnt;
        repeat (10) tick();
        chk("post_reset_pulses", 64'(s_cnt - s0), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
